// File: rtl/apb_io_arbiter_if.sv
// Signal bundle for apb_io_arbiter: both upstream requester ports plus the shared
// downstream peripheral segment. The arbiter uses the slave view, the environment the master view.
interface apb_io_arbiter_if;
  logic [15:0] m0_paddr;
  logic [15:0] m1_paddr;
  logic [7:0]  m0_pwdata;
  logic [7:0]  m1_pwdata;
  logic        m0_pwrite;
  logic        m1_pwrite;
  logic        m0_psel;
  logic        m1_psel;
  logic        m0_penable;
  logic        m1_penable;
  logic [7:0]  m0_prdata;
  logic [7:0]  m1_prdata;
  logic        m0_pready;
  logic        m1_pready;

  logic [2:0]  s_paddr;
  logic [7:0]  s_pwdata;
  logic        s_pwrite;
  logic        s_penable;
  logic [2:0]  s_psel;
  logic [23:0] s_prdata;
  logic [2:0]  s_pready;
  logic        timeout_flag;

  modport slave (
    input  m0_paddr, m1_paddr, m0_pwdata, m1_pwdata, m0_pwrite, m1_pwrite,
    input  m0_psel, m1_psel, m0_penable, m1_penable,
    output m0_prdata, m1_prdata, m0_pready, m1_pready,
    output s_paddr, s_pwdata, s_pwrite, s_penable, s_psel,
    input  s_prdata, s_pready,
    output timeout_flag
  );

  modport master (
    output m0_paddr, m1_paddr, m0_pwdata, m1_pwdata, m0_pwrite, m1_pwrite,
    output m0_psel, m1_psel, m0_penable, m1_penable,
    input  m0_prdata, m1_prdata, m0_pready, m1_pready,
    input  s_paddr, s_pwdata, s_pwrite, s_penable, s_psel,
    output s_prdata, s_pready,
    input  timeout_flag
  );
endinterface

// File: rtl/apb_io_arbiter.sv
// Two-master round-robin APB arbiter and page decoder for the I/O page space.
// Optional ACCESS-phase watchdog enabled by defining APB_IO_ARB_TIMEOUT_EN.
module apb_io_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic             clk,
  input logic             rst,
  apb_io_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e      state_q;
  logic        gnt_q;
  logic        last_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        write_q;
  logic [2:0]  psel_q;
  logic        penable_q;

  logic        mapped;
  logic [1:0]  page;
  logic        slave_ready;
  logic [7:0]  slave_data;
  logic        timeout;
  logic        done;
  logic [7:0]  done_data;
  logic        both_req;
  logic        next_gnt;
  logic [15:0] next_addr;
  logic [2:0]  next_psel;

  assign page   = addr_q[9:8];
  assign mapped = addr_q[15:8] < 8'd3;

  always_comb begin
    slave_ready = 1'b0;
    slave_data  = 8'h00;
    case (page)
      2'd0: begin slave_ready = bus.s_pready[0]; slave_data = bus.s_prdata[7:0];   end
      2'd1: begin slave_ready = bus.s_pready[1]; slave_data = bus.s_prdata[15:8];  end
      2'd2: begin slave_ready = bus.s_pready[2]; slave_data = bus.s_prdata[23:16]; end
      default: ;
    endcase
    if (!mapped) slave_ready = 1'b0;
  end

`ifdef APB_IO_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       flag_q;
  // Fires on the ACCESS cycle whose stall would bring the count to TIMEOUT_CYCLES.
  assign timeout = (state_q == StAccess) && mapped && !slave_ready &&
                   (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT_CYCLES));
  assign bus.timeout_flag = flag_q;
`else
  logic unused_timeout;
  assign unused_timeout   = TIMEOUT_CYCLES[0];
  assign timeout          = 1'b0;
  assign bus.timeout_flag = 1'b0;
`endif

  // Reset in flight aborts the transfer without acknowledging the master.
  assign done      = (state_q == StAccess) && !rst && (!mapped || slave_ready || timeout);
  assign done_data = slave_ready ? slave_data : 8'hFF;

  assign bus.m0_pready = done && !gnt_q;
  assign bus.m1_pready = done && gnt_q;
  assign bus.m0_prdata = (done && !gnt_q) ? done_data : 8'h00;
  assign bus.m1_prdata = (done && gnt_q) ? done_data : 8'h00;

  assign bus.s_paddr   = addr_q[2:0];
  assign bus.s_pwdata  = wdata_q;
  assign bus.s_pwrite  = write_q;
  assign bus.s_psel    = psel_q;
  assign bus.s_penable = penable_q;

  assign both_req  = bus.m0_psel && bus.m1_psel;
  assign next_gnt  = both_req ? ~last_q : bus.m1_psel;
  assign next_addr = next_gnt ? bus.m1_paddr : bus.m0_paddr;

  always_comb begin
    next_psel = 3'b000;
    case (next_addr[15:8])
      8'd0:    next_psel = 3'b001;
      8'd1:    next_psel = 3'b010;
      8'd2:    next_psel = 3'b100;
      default: next_psel = 3'b000;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{addr_q[7:3], bus.m0_penable, bus.m1_penable};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      write_q   <= 1'b0;
      psel_q    <= 3'b000;
      penable_q <= 1'b0;
`ifdef APB_IO_ARB_TIMEOUT_EN
      cnt_q     <= 8'h00;
      flag_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.m0_psel || bus.m1_psel) begin
            gnt_q   <= next_gnt;
            // Fairness pointer only moves on contention.
            if (both_req) last_q <= next_gnt;
            addr_q  <= next_addr;
            wdata_q <= next_gnt ? bus.m1_pwdata : bus.m0_pwdata;
            write_q <= next_gnt ? bus.m1_pwrite : bus.m0_pwrite;
            psel_q  <= next_psel;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          state_q   <= StAccess;
`ifdef APB_IO_ARB_TIMEOUT_EN
          cnt_q     <= 8'h00;
`endif
        end
        StAccess: begin
          if (done) begin
            psel_q    <= 3'b000;
            penable_q <= 1'b0;
            state_q   <= StIdle;
`ifdef APB_IO_ARB_TIMEOUT_EN
            if (timeout) flag_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_io_arbiter.sv
// Bench for apb_io_arbiter: directed scenarios plus randomized two-master traffic,
// all outputs compared each cycle against a transaction-level reference.
module tb_apb_io_arbiter;
  localparam int TimeoutCycles = 4;
`ifdef APB_IO_ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_io_arbiter_if bus();

  apb_io_arbiter #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one outstanding transfer, described by how many cycles ago it was granted.
  bit          mv = 1'b0;
  bit          busy = 1'b0;
  bit          gnt = 1'b0;
  bit          last_m1 = 1'b1;
  bit          to_flag = 1'b0;
  int          age = 0;
  logic [15:0] addr = '0;
  logic [7:0]  wd = '0;
  logic        wr = 1'b0;

  always @(negedge clk) begin
    int         pg;
    logic [2:0] e_psel;
    logic [7:0] rd;
    bit         e_pen, done, by_to;
    pg     = int'(addr[15:8]);
    e_psel = 3'b000;
    if (busy && pg < 3) e_psel[pg] = 1'b1;
    e_pen = busy && age >= 2;
    done  = 1'b0;
    by_to = 1'b0;
    rd    = 8'hFF;
    if (e_pen && !rst) begin
      if (pg >= 3) done = 1'b1;
      else if (bus.s_pready[pg]) begin
        done = 1'b1;
        rd   = bus.s_prdata[pg*8 +: 8];
      end else if (TimeoutEn && (age - 1) == TimeoutCycles) begin
        done  = 1'b1;
        by_to = 1'b1;
      end
    end
    if (mv) begin
      check("s_psel", 32'(bus.s_psel), 32'(e_psel));
      check("s_penable", 32'(bus.s_penable), 32'(e_pen));
      check("m0_pready", 32'(bus.m0_pready), 32'(done && !gnt));
      check("m1_pready", 32'(bus.m1_pready), 32'(done && gnt));
      check("m0_prdata", 32'(bus.m0_prdata), 32'((done && !gnt) ? rd : 8'h00));
      check("m1_prdata", 32'(bus.m1_prdata), 32'((done && gnt) ? rd : 8'h00));
      check("timeout_flag", 32'(bus.timeout_flag), 32'(to_flag));
      if (busy) begin
        check("s_paddr", 32'(bus.s_paddr), 32'(addr[2:0]));
        check("s_pwdata", 32'(bus.s_pwdata), 32'(wd));
        check("s_pwrite", 32'(bus.s_pwrite), 32'(wr));
      end
    end
    if (rst) begin
      mv      = 1'b1;
      busy    = 1'b0;
      last_m1 = 1'b1;
      to_flag = 1'b0;
    end else if (busy) begin
      if (done) begin
        busy = 1'b0;
        if (by_to) to_flag = 1'b1;
      end else age++;
    end else if (bus.m0_psel || bus.m1_psel) begin
      if (bus.m0_psel && bus.m1_psel) begin
        gnt     = !last_m1;
        last_m1 = gnt;
      end else gnt = bus.m1_psel;
      addr = gnt ? bus.m1_paddr : bus.m0_paddr;
      wd   = gnt ? bus.m1_pwdata : bus.m0_pwdata;
      wr   = gnt ? bus.m1_pwrite : bus.m0_pwrite;
      busy = 1'b1;
      age  = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic sel, input logic [15:0] a, input logic [7:0] d,
                       input logic w);
    if (m == 0) begin
      bus.m0_psel = sel; bus.m0_paddr = a; bus.m0_pwdata = d; bus.m0_pwrite = w;
      bus.m0_penable = 1'b0;
    end else begin
      bus.m1_psel = sel; bus.m1_paddr = a; bus.m1_pwdata = d; bus.m1_pwrite = w;
      bus.m1_penable = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_psel"}, 32'(bus.s_psel), 32'h0);
    check({tag, "_s_penable"}, 32'(bus.s_penable), 32'h0);
    check({tag, "_s_paddr"}, 32'(bus.s_paddr), 32'h0);
    check({tag, "_s_pwdata"}, 32'(bus.s_pwdata), 32'h0);
    check({tag, "_s_pwrite"}, 32'(bus.s_pwrite), 32'h0);
    check({tag, "_m0_pready"}, 32'(bus.m0_pready), 32'h0);
    check({tag, "_m1_pready"}, 32'(bus.m1_pready), 32'h0);
    check({tag, "_m0_prdata"}, 32'(bus.m0_prdata), 32'h0);
    check({tag, "_m1_prdata"}, 32'(bus.m1_prdata), 32'h0);
    check({tag, "_timeout_flag"}, 32'(bus.timeout_flag), 32'h0);
  endtask

  task automatic rand_req(output logic [15:0] a, output logic [7:0] d, output logic w);
    int unsigned s;
    logic [7:0]  pg;
    s = $urandom_range(0, 9);
    if (s < 7) pg = 8'(s % 3);
    else if (s == 7) pg = 8'd3;
    else pg = 8'($urandom_range(4, 255));
    a = {pg, 8'($urandom)};
    d = 8'($urandom);
    w = 1'($urandom);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;
    logic        r0, r1;
    set_m(0, 1'b0, 16'h0, 8'h0, 1'b0);
    set_m(1, 1'b0, 16'h0, 8'h0, 1'b0);
    bus.s_pready = 3'b000;
    bus.s_prdata = 24'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // Single m0 read, page 1, zero-wait slave.
    step(); set_m(0, 1'b1, 16'h0103, 8'h00, 1'b0);
    bus.s_pready = 3'b111; bus.s_prdata = 24'h00_5A_00;
    @(negedge clk); check("t1_idle_psel", 32'(bus.s_psel), 32'h0);
    step(); @(negedge clk);
    check("t1_setup_psel", 32'(bus.s_psel), 32'b010);
    check("t1_setup_pen", 32'(bus.s_penable), 32'h0);
    check("t1_setup_paddr", 32'(bus.s_paddr), 32'h3);
    step(); @(negedge clk);
    check("t1_access_pen", 32'(bus.s_penable), 32'h1);
    check("t1_m0_pready", 32'(bus.m0_pready), 32'h1);
    check("t1_m0_prdata", 32'(bus.m0_prdata), 32'h5A);
    step(); set_m(0, 1'b0, 16'h0, 8'h0, 1'b0);

    // Simultaneous writes to page 0, twice: m0 first, then m1 first.
    step(); set_m(0, 1'b1, 16'h0001, 8'h11, 1'b1); set_m(1, 1'b1, 16'h0002, 8'h22, 1'b1);
    step(); @(negedge clk);
    check("t2_first_wdata", 32'(bus.s_pwdata), 32'h11);
    check("t2_first_write", 32'(bus.s_pwrite), 32'h1);
    step(); @(negedge clk);
    check("t2_m0_done", 32'(bus.m0_pready), 32'h1);
    check("t2_m1_wait", 32'(bus.m1_pready), 32'h0);
    step(); set_m(0, 1'b0, 16'h0, 8'h0, 1'b0);
    step(); @(negedge clk); check("t2_second_wdata", 32'(bus.s_pwdata), 32'h22);
    step(); @(negedge clk); check("t2_m1_done", 32'(bus.m1_pready), 32'h1);
    step(); set_m(0, 1'b1, 16'h0003, 8'h33, 1'b1); set_m(1, 1'b1, 16'h0004, 8'h44, 1'b1);
    step(); @(negedge clk); check("t2_pair2_first", 32'(bus.s_pwdata), 32'h44);
    step(); @(negedge clk); check("t2_pair2_m1_done", 32'(bus.m1_pready), 32'h1);
    step(); set_m(1, 1'b0, 16'h0, 8'h0, 1'b0);
    step(); @(negedge clk); check("t2_pair2_second", 32'(bus.s_pwdata), 32'h33);
    step(); @(negedge clk); check("t2_pair2_m0_done", 32'(bus.m0_pready), 32'h1);
    step(); set_m(0, 1'b0, 16'h0, 8'h0, 1'b0);

    // m1 read from unmapped page 7.
    step(); set_m(1, 1'b1, 16'h0700, 8'h00, 1'b0); bus.s_pready = 3'b000;
    step(); @(negedge clk); check("t3_psel", 32'(bus.s_psel), 32'h0);
    step(); @(negedge clk);
    check("t3_m1_pready", 32'(bus.m1_pready), 32'h1);
    check("t3_m1_prdata", 32'(bus.m1_prdata), 32'hFF);
    check("t3_flag", 32'(bus.timeout_flag), 32'h0);
    step(); set_m(1, 1'b0, 16'h0, 8'h0, 1'b0);

`ifdef APB_IO_ARB_TIMEOUT_EN
    // Page 2 never ready: forced completion on the 4th ACCESS cycle.
    step(); set_m(0, 1'b1, 16'h0205, 8'h00, 1'b0);
    step(); @(negedge clk); check("t4_psel", 32'(bus.s_psel), 32'b100);
    for (int k = 1; k <= 4; k++) begin
      step(); @(negedge clk);
      check("t4_m0_pready", 32'(bus.m0_pready), 32'(k == 4));
    end
    check("t4_m0_prdata", 32'(bus.m0_prdata), 32'hFF);
    step(); set_m(0, 1'b0, 16'h0, 8'h0, 1'b0);
    @(negedge clk); check("t4_flag_set", 32'(bus.timeout_flag), 32'h1);
    repeat (3) step();
    @(negedge clk); check("t4_flag_sticky", 32'(bus.timeout_flag), 32'h1);
`endif

    // Reset during ACCESS; m0 must not be acknowledged and wins the next contention.
    step(); set_m(0, 1'b1, 16'h0104, 8'hA5, 1'b1); bus.s_pready = 3'b000;
    step();
    step(); @(negedge clk); check("t5_access", 32'(bus.s_penable), 32'h1);
    step(); rst = 1'b1;
    @(negedge clk); check("t5_no_ack", 32'(bus.m0_pready), 32'h0);
    step(); rst = 1'b0; set_m(1, 1'b1, 16'h0001, 8'h77, 1'b1);
    @(negedge clk); check_reset_vals("t5_post");
    step(); bus.s_pready = 3'b111;
    @(negedge clk); check("t5_m0_wins", 32'(bus.s_psel), 32'b010);
    step(); @(negedge clk); check("t5_m0_done", 32'(bus.m0_pready), 32'h1);
    step(); set_m(0, 1'b0, 16'h0, 8'h0, 1'b0); set_m(1, 1'b0, 16'h0, 8'h0, 1'b0);
    step();

    // Randomized traffic with slave wait states and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      r0 = bus.m0_pready;
      r1 = bus.m1_pready;
      step();
      rst = ($urandom_range(0, 299) == 0);
      bus.s_pready = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) != 0};
      bus.s_prdata = 24'($urandom);
      if (bus.m0_psel && !r0) bus.m0_penable = 1'b1;
      else if ($urandom_range(0, 2) == 0) begin
        rand_req(a, d, w);
        set_m(0, 1'b1, a, d, w);
      end else set_m(0, 1'b0, bus.m0_paddr, bus.m0_pwdata, bus.m0_pwrite);
      if (bus.m1_psel && !r1) bus.m1_penable = 1'b1;
      else if ($urandom_range(0, 2) == 0) begin
        rand_req(a, d, w);
        set_m(1, 1'b1, a, d, w);
      end else set_m(1, 1'b0, bus.m1_paddr, bus.m1_pwdata, bus.m1_pwrite);
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
